// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-granular N-to-1 Avalon-ST arbiter. Round-robin by default; define
// AVST_ARB_FIXED_PRIO_EN for fixed priority (lowest asserted index wins).
module avalon_st_pkt_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [NUM_IN*DATA_W-1:0]    in_data,
  input  logic [NUM_IN-1:0]           in_startofpacket,
  input  logic [NUM_IN-1:0]           in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_startofpacket,
  output logic                        out_endofpacket,
  output logic [EMPTY_W-1:0]          out_empty,
  output logic [NUM_IN-1:0]           grant,
  output logic                        proto_err
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, PKT} state_e;

  state_e             state_q;
  logic [NUM_IN-1:0]  grant_q;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   win_d;
  logic               first_beat_q;
  logic               proto_err_q;
  logic               active;
  logic               xfer;
  logic               bad_beat;

`ifdef AVST_ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win_d = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) win_d = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Search starts at ptr and wraps modulo NUM_IN; the first valid requester wins.
  always_comb begin
    win_d = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_IN)) sum = sum - (IDX_W+1)'(NUM_IN);
      idx = sum[IDX_W-1:0];
      if (!found && in_valid[idx]) begin
        win_d = idx;
        found = 1'b1;
      end
    end
  end
`endif

  assign active            = (state_q == PKT);
  assign out_valid         = active & in_valid[win_q];
  assign out_data          = active ? in_data[win_q*DATA_W +: DATA_W] : '0;
  assign out_startofpacket = active & in_startofpacket[win_q];
  assign out_endofpacket   = active & in_endofpacket[win_q];
  assign out_empty         = active ? in_empty[win_q*EMPTY_W +: EMPTY_W] : '0;
  assign in_ready          = grant_q & {NUM_IN{out_ready}};
  assign grant             = grant_q;
  assign proto_err         = proto_err_q;

  assign xfer     = out_valid & out_ready;
  assign bad_beat = first_beat_q ? ~out_startofpacket : out_startofpacket;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      win_q        <= '0;
      first_beat_q <= 1'b0;
      proto_err_q  <= 1'b0;
`ifndef AVST_ARB_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      case (state_q)
        IDLE: begin
          if (|in_valid) begin
            win_q        <= win_d;
            grant_q      <= NUM_IN'(1) << win_d;
            first_beat_q <= 1'b1;
            state_q      <= PKT;
          end
        end
        PKT: begin
          if (xfer) begin
            first_beat_q <= 1'b0;
            if (bad_beat) proto_err_q <= 1'b1;
            if (out_endofpacket) begin
              state_q <= IDLE;
              grant_q <= '0;
`ifndef AVST_ARB_FIXED_PRIO_EN
              ptr_q   <= (win_q == IDX_W'(NUM_IN - 1)) ? '0 : win_q + 1'b1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Directed bench for avalon_st_pkt_arbiter (NUM_IN=4, DATA_W=32, EMPTY_W=2).
// A small per-requester producer model feeds packets; expected values are hand-derived.
module tb_avalon_st_pkt_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_startofpacket;
  logic [3:0]   in_endofpacket;
  logic [7:0]   in_empty;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_startofpacket;
  logic         out_endofpacket;
  logic [1:0]   out_empty;
  logic [3:0]   grant;
  logic         proto_err;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  // Producer model state
  logic [3:0]  en;
  logic [3:0]  rep;
  logic [3:0]  bad;
  int          len [4];
  int          beat[4];
  logic [31:0] base[4];
  logic [1:0]  last_empty[4];

  int or_seq  [5] = '{1, 0, 0, 1, 1};
  int exp_beat[5] = '{0, 1, 1, 1, 2};

  avalon_st_pkt_arbiter #(.NUM_IN(4), .DATA_W(32), .EMPTY_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .grant(grant), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_all();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]            = en[i];
      in_data[i*32 +: 32]    = base[i] + 32'(beat[i]);
      in_startofpacket[i]    = bad[i] ? (beat[i] == 1) : (beat[i] == 0);
      in_endofpacket[i]      = (beat[i] == len[i] - 1);
      in_empty[i*2 +: 2]     = (beat[i] == len[i] - 1) ? last_empty[i] : 2'd0;
    end
  endtask

  task automatic clear_producers();
    en = '0; rep = '0; bad = '0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 1; beat[i] = 0; base[i] = '0; last_empty[i] = '0;
    end
  endtask

  // Advance one clock; producers step past any beat that handshook at the edge.
  task automatic tick();
    logic [3:0] acc;
    acc = in_ready & in_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        xfers++;
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          if (!rep[i]) en[i] = 1'b0;
        end else begin
          beat[i] = beat[i] + 1;
        end
      end
    end
    drive_all();
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_producers();
    drive_all();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    xfers   = 0;
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_producers();
    en = 4'hF;
    drive_all();
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    checks++; if ({out_valid, out_startofpacket, out_endofpacket} !== 3'b0) begin
      errors++; $display("FAIL reset_out_ctrl: got %b want 000", {out_valid, out_startofpacket, out_endofpacket}); end
    checks++; if ({out_data, out_empty} !== 34'b0) begin
      errors++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_data, out_empty); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_held_grant: got %b want 0000", grant); end
  endtask

  task automatic test_single();
    do_reset();
    en[2] = 1'b1; len[2] = 3; base[2] = 32'hA0; last_empty[2] = 2'd2;
    drive_all();
    #1;
    checks++; if ({grant, in_ready, out_valid} !== 9'b0) begin
      errors++; $display("FAIL single_idle: got grant=%b in_ready=%b out_valid=%b want all 0", grant, in_ready, out_valid); end
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready: got %b want 0100", in_ready); end
    checks++; if ({out_data, out_startofpacket, out_endofpacket} !== {32'hA0, 2'b10}) begin
      errors++; $display("FAIL single_beat1: got %h sop=%b eop=%b want a0 sop=1 eop=0", out_data, out_startofpacket, out_endofpacket); end
    tick();
    checks++; if ({out_data, out_startofpacket, out_endofpacket} !== {32'hA1, 2'b00}) begin
      errors++; $display("FAIL single_beat2: got %h sop=%b eop=%b want a1 sop=0 eop=0", out_data, out_startofpacket, out_endofpacket); end
    tick();
    checks++; if ({out_data, out_startofpacket, out_endofpacket, out_empty} !== {32'hA2, 2'b01, 2'd2}) begin
      errors++; $display("FAIL single_beat3: got %h sop=%b eop=%b empty=%0d want a2 sop=0 eop=1 empty=2",
                         out_data, out_startofpacket, out_endofpacket, out_empty); end
    tick();
    checks++; if ({grant, out_valid, proto_err} !== 6'b0) begin
      errors++; $display("FAIL single_done: got grant=%b out_valid=%b proto_err=%b want 0", grant, out_valid, proto_err); end
    checks++; if (xfers !== 3) begin errors++; $display("FAIL single_xfers: got %0d want 3", xfers); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int w;
    do_reset();
    en = 4'hF; rep = 4'hF;
    for (int i = 0; i < 4; i++) begin len[i] = 2; base[i] = 32'(i * 256); end
    drive_all();
    #1;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rr_idle: got %b want 0000", grant); end
    for (int k = 1; k <= 14; k++) begin
      tick();
      w     = (k / 3) % 4;
      exp_g = (k % 3 == 0) ? 4'b0 : 4'(1 << w);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp_g); end
      if (k % 3 != 0) begin
        checks++; if ({out_data, out_startofpacket} !== {32'(w * 256 + (k % 3) - 1), (k % 3 == 1)}) begin
          errors++; $display("FAIL rr_data[%0d]: got %h sop=%b want %h sop=%b", k, out_data, out_startofpacket,
                             32'(w * 256 + (k % 3) - 1), (k % 3 == 1)); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: got out_valid=%b want 0", k, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en[1] = 1'b1; len[1] = 3; base[1] = 32'hB0;
    drive_all();
    #1;
    for (int c = 0; c < 5; c++) begin
      tick();
      out_ready = (or_seq[c] != 0);
      #1;
      checks++; if (in_ready !== {2'b00, out_ready, 1'b0}) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, {2'b00, out_ready, 1'b0}); end
      checks++; if ({out_valid, out_data} !== {1'b1, 32'hB0 + 32'(exp_beat[c])}) begin
        errors++; $display("FAIL bp_data[%0d]: got valid=%b %h want valid=1 %h", c, out_valid, out_data,
                           32'hB0 + 32'(exp_beat[c])); end
    end
    tick();
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL bp_done_grant: got %b want 0000", grant); end
    checks++; if (xfers !== 3) begin errors++; $display("FAIL bp_xfers: got %0d want 3", xfers); end
  endtask

  task automatic test_violation();
    do_reset();
    en[3] = 1'b1; len[3] = 2; bad[3] = 1'b1; base[3] = 32'hC0;
    drive_all();
    #1;
    tick();
    checks++; if ({grant, out_valid, out_startofpacket, out_data, proto_err} !== {4'b1000, 2'b10, 32'hC0, 1'b0}) begin
      errors++; $display("FAIL viol_beat1: got grant=%b v=%b sop=%b %h perr=%b want 1000 v=1 sop=0 c0 perr=0",
                         grant, out_valid, out_startofpacket, out_data, proto_err); end
    tick();
    checks++; if ({out_valid, out_startofpacket, out_data} !== {2'b11, 32'hC1}) begin
      errors++; $display("FAIL viol_beat2: got v=%b sop=%b %h want v=1 sop=1 c1", out_valid, out_startofpacket, out_data); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL viol_err_rise: got %b want 1", proto_err); end
    repeat (4) tick();
    checks++; if ({grant, proto_err} !== 5'b00001) begin
      errors++; $display("FAIL viol_err_sticky: got grant=%b perr=%b want 0000 1", grant, proto_err); end
    reset_n = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL viol_err_reset: got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    en = 4'b0011;
    len[0] = 1; base[0] = 32'hD0;
    len[1] = 4; base[1] = 32'hE0;
    drive_all();
    #1;
    tick();
    checks++; if ({grant, out_startofpacket, out_endofpacket, out_data} !== {4'b0001, 2'b11, 32'hD0}) begin
      errors++; $display("FAIL mid_single_beat: got grant=%b sop=%b eop=%b %h want 0001 1 1 d0",
                         grant, out_startofpacket, out_endofpacket, out_data); end
    tick();
    tick();
    checks++; if ({grant, out_data, proto_err} !== {4'b0010, 32'hE0, 1'b0}) begin
      errors++; $display("FAIL mid_second_pkt: got grant=%b %h perr=%b want 0010 e0 0", grant, out_data, proto_err); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if ({grant, in_ready, out_valid, out_startofpacket, out_endofpacket} !== 11'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: got grant=%b in_ready=%b v=%b sop=%b eop=%b want all 0",
                         grant, in_ready, out_valid, out_startofpacket, out_endofpacket); end
    checks++; if ({out_data, out_empty} !== 34'b0) begin
      errors++; $display("FAIL mid_reset_data: got %h/%h want 0/0", out_data, out_empty); end
    @(posedge clk);
    #1;
    clear_producers();
    en = 4'b0011; rep = 4'b0011; len[0] = 2; len[1] = 2;
    drive_all();
    reset_n = 1'b1;
    #1;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", grant); end
  endtask

  task automatic test_two_streams();
    logic [3:0] exp_g;
    do_reset();
    en = 4'b1010; rep = 4'b1010; len[1] = 2; len[3] = 2; base[1] = 32'h100; base[3] = 32'h300;
    drive_all();
    #1;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef AVST_ARB_FIXED_PRIO_EN
      exp_g = (k % 3 == 0) ? 4'b0 : 4'b0010;
`else
      exp_g = (k % 3 == 0) ? 4'b0 : (((k / 3) % 2 == 1) ? 4'b1000 : 4'b0010);
`endif
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL two_grant[%0d]: got %b want %b", k, grant, exp_g); end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_producers();
    drive_all();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_violation();
    test_reset_mid_packet();
    test_two_streams();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
